// File: rtl/spi_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter_if
// Bundles the client request side and the SPI_MASTER control side of the
// round-robin SPI arbiter into one interface.
//
// Signals:
//   req        client -> arb   one request bit per client
//   req_data   client -> arb   word for client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   done       arb -> client   one-cycle pulse, transfer finished
//   err        arb -> client   one-cycle pulse, transfer timed out
//   busy       arb -> client   high whenever the arbiter is not idle
//   grant_idx  arb -> client   index of current/last granted client
//   spi_start  arb -> master   one-cycle launch strobe
//   spi_data   arb -> master   transmit word, stable from launch to finish
//   spi_finish master -> arb   end-of-transfer indication
//
// Modports:
//   master  the arbiter side (drives done/err/busy/grant/spi_start/spi_data)
//   slave   the environment side (clients plus SPI_MASTER)
// ---------------------------------------------------------------------------
interface spi_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            err;
  logic                          busy;
  logic [IDX_W-1:0]              grant_idx;
  logic                          spi_start;
  logic [DATA_WIDTH-1:0]         spi_data;
  logic                          spi_finish;

  modport master (
    input  req, req_data, spi_finish,
    output done, err, busy, grant_idx, spi_start, spi_data
  );

  modport slave (
    output req, req_data, spi_finish,
    input  done, err, busy, grant_idx, spi_start, spi_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter
// Round-robin scheduler letting NUM_REQ clients share one SPI_MASTER.
// A pending request is picked searching upward from a rotating pointer,
// launched with a single-cycle spi_start, and its word is held on spi_data
// until the master finishes. A watchdog aborts transfers that never finish,
// and a fixed idle gap separates consecutive transfers.
//
// Ports:
//   clk   system clock, all state updates on its rising edge
//   rst   synchronous active-high reset
//   bus   spi_master_arbiter_if.master (client handshake + master control)
//
// Parameters:
//   NUM_REQ     number of clients (2..16)
//   DATA_WIDTH  transfer word width, equal to the master's word width
//   GAP_CYCLES  idle cycles between end of a transfer and next arbitration
//   TIMEOUT     cycles allowed in BUSY before the transfer is aborted
// ---------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_master_arbiter_if.master     bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      grant_idx_q;
  logic [DATA_WIDTH-1:0] spi_data_q;
  logic                  spi_start_q;
  logic                  busy_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [NUM_REQ-1:0]    err_q;
  logic [WD_W-1:0]       wd_q;
  logic [GAP_W-1:0]      gap_q;

  // Per-client view of the packed request words.
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan offsets from the highest down so that the
  // smallest offset from ptr_q (i.e. the first requester at or above the
  // pointer, wrapping) is the one left standing.
  logic             sel_valid_d;
  logic [IDX_W-1:0] sel_idx_d;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    sel_valid_d = 1'b0;
    sel_idx_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int c;
      c = int'(ptr_q) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (bus.req[c]) begin
        sel_valid_d = 1'b1;
        sel_idx_d   = IDX_W'(c);
      end
    end
    // Pointer moves just past the winner so it drops to lowest priority.
    ptr_d = (sel_idx_d == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      spi_data_q  <= '0;
      spi_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      spi_start_q <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      case (state_q)
        IDLE: begin
          if (sel_valid_d) begin
            grant_idx_q <= sel_idx_d;
            spi_data_q  <= req_word[sel_idx_d];
            ptr_q       <= ptr_d;
            spi_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_q    <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          // Finish is checked first so it wins over a same-cycle timeout.
          if (bus.spi_finish) begin
            done_q[grant_idx_q] <= 1'b1;
            gap_q               <= '0;
            state_q             <= GAP;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            err_q[grant_idx_q] <= 1'b1;
            gap_q              <= '0;
            state_q            <= GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.spi_start = spi_start_q;
  assign bus.spi_data  = spi_data_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_master_arbiter
// Directed bench: stimulus pushes expected transactions into a scoreboard
// array; a monitor checks every launch, done/err pulse, reset and timing
// relation as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_spi_master_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int GAP     = 4;
  localparam int TMO     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  spi_master_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_q = 1'b1;   // reset as seen by the DUT on the last rising edge
  always @(posedge clk) rst_q <= rst;

  // ---------------- client model ----------------
  int target [NUM_REQ];            // requests issued (stimulus only)
  int served [NUM_REQ];            // done/err pulses seen (client process only)
  logic [DW-1:0] cdata [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cli
    assign bus.req[gi] = (target[gi] > served[gi]);
    assign bus.req_data[gi*DW +: DW] = cdata[gi];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.done[i] || bus.err[i]) served[i] = served[i] + 1;
  end

  // ---------------- SPI master model ----------------
  int dly [NUM_REQ];   // cycles from start to finish; negative = never
  int mcnt = -1;
  int fin_cyc = -1;

  always @(negedge clk) begin
    bus.spi_finish = 1'b0;
    if (rst_q) begin
      mcnt = -1;
    end else if (bus.spi_start) begin
      mcnt = dly[bus.grant_idx];
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        bus.spi_finish = 1'b1;
        fin_cyc = cyc;
        mcnt = -1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    bit          is_err;
  } exp_t;

  exp_t exp_arr [64];
  int   wr_n = 0;
  int   rd_n = 0;

  int vecs = 0;
  int miss = 0;

  task automatic check(input string name, input int act, input int req);
    vecs++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  int   last_start = -1;
  int   last_end   = -1;
  logic prev_busy  = 1'b0;
  logic prev_start = 1'b0;
  logic [DW-1:0] prev_data = '0;
  exp_t e;

  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_busy",      int'(bus.busy),      0);
      check("rst_spi_start", int'(bus.spi_start), 0);
      check("rst_done",      int'(bus.done),      0);
      check("rst_err",       int'(bus.err),       0);
      check("rst_grant_idx", int'(bus.grant_idx), 0);
      check("rst_spi_data",  int'(bus.spi_data),  0);
      last_end = -1;
    end else begin
      if (bus.spi_start) begin
        check("start_width", int'(prev_start), 0);
        check("start_busy",  int'(bus.busy),   1);
        check("start_pending", int'(rd_n < wr_n), 1);
        if (rd_n < wr_n) begin
          check("grant_idx", int'(bus.grant_idx), exp_arr[rd_n].idx);
          check("spi_data",  int'(bus.spi_data),  int'(exp_arr[rd_n].data));
        end
        if (last_end >= 0) check("start_spacing", int'(cyc - last_end >= GAP + 1), 1);
        last_start = cyc;
      end
      if (prev_busy && bus.busy) check("data_hold", int'(bus.spi_data), int'(prev_data));
      if (prev_busy && !bus.busy) check("gap_len", cyc - last_end, GAP);
      if (bus.done != '0 || bus.err != '0) begin
        check("pulse_pending", int'(rd_n < wr_n), 1);
        if (rd_n < wr_n) begin
          e = exp_arr[rd_n];
          rd_n++;
          check("done_vec", int'(bus.done), e.is_err ? 0 : (1 << e.idx));
          check("err_vec",  int'(bus.err),  e.is_err ? (1 << e.idx) : 0);
          if (e.is_err) check("err_time", cyc - last_start, TMO + 1);
          else          check("done_time", cyc - fin_cyc, 1);
          $display("txn client %0d data %02h %s at cycle %0d",
                   e.idx, bus.spi_data, bus.err != '0 ? "err" : "done", cyc);
        end
        last_end = cyc;
      end
    end
    prev_busy  = bus.busy;
    prev_start = bus.spi_start;
    prev_data  = bus.spi_data;
  end

  // ---------------- stimulus ----------------
  task automatic push(input int idx, input logic [DW-1:0] d, input bit is_err);
    exp_arr[wr_n] = '{idx, d, is_err};
    wr_n++;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n;
    n = 0;
    while (!(rd_n == wr_n && !bus.busy && !bus.spi_start)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        $display("FAIL %s: no idle within %0d cycles", tag, budget);
        $fatal(1, "bench stopped on timeout");
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cdata[i] = '0;
      dly[i]   = 10;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single request from client 2, finish 20 cycles after start.
    cdata[2] = 8'hA5; dly[2] = 20;
    push(2, 8'hA5, 1'b0);
    target[2]++;
    wait_quiet(200, "single");

    // Reset, then clients 1 and 3 together: ptr=0 so 1 wins, then 3.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    cdata[1] = 8'h3C; cdata[3] = 8'hC3; dly[1] = 20; dly[3] = 20;
    push(1, 8'h3C, 1'b0);
    push(3, 8'hC3, 1'b0);
    target[1]++; target[3]++;
    wait_quiet(300, "simultaneous");

    // Fairness: ptr=0, all four requesting; 0 and 1 re-raise once.
    cdata[0] = 8'h10; cdata[1] = 8'h21; cdata[2] = 8'h32; cdata[3] = 8'h43;
    for (int i = 0; i < NUM_REQ; i++) dly[i] = 5;
    push(0, 8'h10, 1'b0); push(1, 8'h21, 1'b0); push(2, 8'h32, 1'b0);
    push(3, 8'h43, 1'b0); push(0, 8'h10, 1'b0); push(1, 8'h21, 1'b0);
    target[0] += 2; target[1] += 2; target[2]++; target[3]++;
    wait_quiet(400, "fairness");

    // Timeout: ptr=2, client 2 never finishes, client 3 then served.
    cdata[2] = 8'h5A; cdata[3] = 8'hE7; dly[2] = -1; dly[3] = 8;
    push(2, 8'h5A, 1'b1);
    push(3, 8'hE7, 1'b0);
    target[2]++; target[3]++;
    wait_quiet(300, "timeout");

    // Collision: finish lands on watchdog count TIMEOUT-1; done wins.
    cdata[1] = 8'h99; dly[1] = 64;
    push(1, 8'h99, 1'b0);
    target[1]++;
    wait_quiet(200, "collision");

    // Reset mid-BUSY: ptr=3 before reset, so only a cleared ptr lets
    // client 2 be re-granted ahead of client 3.
    cdata[2] = 8'h6E; cdata[3] = 8'hF0; dly[2] = 20; dly[3] = 6;
    push(2, 8'h6E, 1'b0);
    push(3, 8'hF0, 1'b0);
    target[2]++;
    begin
      int n;
      n = 0;
      while (!bus.spi_start) begin
        @(negedge clk);
        n++;
        if (n > 50) begin
          $display("FAIL reset_launch: no spi_start within 50 cycles");
          $fatal(1, "bench stopped on timeout");
        end
      end
    end
    repeat (5) @(negedge clk);
    target[3]++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_quiet(300, "reset_mid_busy");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
